// File: rtl/dual_chan_pass_pkg.sv
// Shared constants and helpers for dual_chan_pass_fifo.
// Holds pointer-width helper, stats width and lockstep mode encodings.
package dual_chan_pass_pkg;

    localparam int STATS_W      = 16;
    localparam int LOCKSTEP_OFF = 0;
    localparam int LOCKSTEP_ON  = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dual_chan_pass_fifo_chan.sv
// Single-channel circular FIFO used by dual_chan_pass_fifo.
// Push/pop strobes are masked internally by full/empty.
module chan_fifo
    import dual_chan_pass_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic [clog2(DEPTH):0]    o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage: cleared on reset, written at the write pointer on push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks push/pop balance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/dual_chan_pass_fifo.sv
// Two-channel buffered pass-through with optional lockstep popping.
// Define DUAL_CHAN_PASS_STATS_EN to add per-channel pop counters.
module dual_chan_pass_fifo
    import dual_chan_pass_pkg::*;
#(
    parameter int WIDTH1   = 8,
    parameter int WIDTH2   = 6,
    parameter int DEPTH    = 4,
    parameter int LOCKSTEP = LOCKSTEP_OFF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in1_valid,
    output logic                    in1_ready,
    input  logic [WIDTH1-1:0]       in1_data,
    input  logic                    in2_valid,
    output logic                    in2_ready,
    input  logic [WIDTH2-1:0]       in2_data,
    output logic                    out1_valid,
    input  logic                    out1_ready,
    output logic [WIDTH1-1:0]       out1_data,
    output logic                    out2_valid,
    input  logic                    out2_ready,
    output logic [WIDTH2-1:0]       out2_data,
`ifdef DUAL_CHAN_PASS_STATS_EN
    output logic [STATS_W-1:0]      pop_cnt1,
    output logic [STATS_W-1:0]      pop_cnt2,
`endif
    output logic [clog2(DEPTH):0]   count1,
    output logic [clog2(DEPTH):0]   count2
);

    logic w_push1;
    logic w_push2;
    logic w_pop1;
    logic w_pop2;
    logic w_empty1;
    logic w_empty2;
    logic w_full1;
    logic w_full2;

    chan_fifo #(
        .WIDTH (WIDTH1),
        .DEPTH (DEPTH)
    ) u_ch1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push1),
        .i_pop   (w_pop1),
        .i_data  (in1_data),
        .o_data  (out1_data),
        .o_count (count1),
        .o_empty (w_empty1),
        .o_full  (w_full1)
    );

    chan_fifo #(
        .WIDTH (WIDTH2),
        .DEPTH (DEPTH)
    ) u_ch2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push2),
        .i_pop   (w_pop2),
        .i_data  (in2_data),
        .o_data  (out2_data),
        .o_count (count2),
        .o_empty (w_empty2),
        .o_full  (w_full2)
    );

    // Ready depends only on registered fullness, so a pop never frees a slot
    // for a push in the same cycle.
    assign in1_ready = ~w_full1;
    assign in2_ready = ~w_full2;
    assign w_push1   = in1_valid & ~w_full1;
    assign w_push2   = in2_valid & ~w_full2;

    generate
        if (LOCKSTEP == LOCKSTEP_ON) begin : g_lock
            logic w_both;
            logic w_pop_both;
            assign w_both     = ~w_empty1 & ~w_empty2;
            assign w_pop_both = w_both & out1_ready & out2_ready;
            assign out1_valid = w_both;
            assign out2_valid = w_both;
            assign w_pop1     = w_pop_both;
            assign w_pop2     = w_pop_both;
        end else begin : g_indep
            assign out1_valid = ~w_empty1;
            assign out2_valid = ~w_empty2;
            assign w_pop1     = ~w_empty1 & out1_ready;
            assign w_pop2     = ~w_empty2 & out2_ready;
        end
    endgenerate

`ifdef DUAL_CHAN_PASS_STATS_EN
    logic [STATS_W-1:0] r_pop_cnt1;
    logic [STATS_W-1:0] r_pop_cnt2;

    // Free-running pop counters, wrapping at 2^STATS_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pop_cnt1 <= '0;
            r_pop_cnt2 <= '0;
        end else begin
            if (w_pop1) begin
                r_pop_cnt1 <= r_pop_cnt1 + STATS_W'(1);
            end
            if (w_pop2) begin
                r_pop_cnt2 <= r_pop_cnt2 + STATS_W'(1);
            end
        end
    end

    assign pop_cnt1 = r_pop_cnt1;
    assign pop_cnt2 = r_pop_cnt2;
`else
`endif

endmodule
